// File: rtl/axi_hs_pkg.sv
// Shared width helpers and error-bit indices for the write-response handshake tracker.
package axi_hs_pkg;

    localparam int ERR_UNEXP_IDX = 0;
    localparam int ERR_TO_IDX    = 1;
    localparam int ERR_BITS      = 2;

    // Width of a counter able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int to_w(input int timeout_cycles);
        return (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wr_hs_channel.sv
// One B-channel tracker: outstanding count, response wait timer, done pulse and sticky errors.
module wr_hs_channel
    import axi_hs_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 256,
    parameter int CNT_W           = cnt_w(MAX_OUTSTANDING),
    parameter int TO_W            = to_w(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             req_i,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic             err_clear_i,
    output logic             req_ready_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o,
    output logic             err_unexp_o,
    output logic             err_to_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                done_q, done_d;
    logic [ERR_BITS-1:0] err_q, err_d;
    logic                acc, hs, cnt_zero, unexp_evt, to_evt;

    assign cnt_zero    = (cnt_q == '0);
    assign req_ready_o = (cnt_q != CNT_MAX);
    assign acc         = req_i & req_ready_o;
    assign hs          = valid_i & ready_i;

    always_comb begin
        cnt_d     = cnt_q;
        to_d      = '0;
        to_evt    = 1'b0;
        unexp_evt = hs & cnt_zero;
        done_d    = hs & ~cnt_zero;

        // A response with nothing outstanding never decrements; it only flags an error.
        if (acc && (!hs || cnt_zero)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (hs && !acc && !cnt_zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (TIMEOUT_CYCLES != 0 && !hs && !cnt_zero) begin
            to_d   = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);
            to_evt = (to_q == TO_LAST);
        end

        // New error events win over a simultaneous clear.
        err_d                = err_q & {ERR_BITS{~err_clear_i}};
        err_d[ERR_UNEXP_IDX] = err_d[ERR_UNEXP_IDX] | unexp_evt;
        err_d[ERR_TO_IDX]    = err_d[ERR_TO_IDX] | to_evt;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q  <= '0;
            to_q   <= '0;
            done_q <= 1'b0;
            err_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            to_q   <= to_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign done_o      = done_q;
    assign cnt_o       = cnt_q;
    assign busy_o      = ~cnt_zero;
    assign err_unexp_o = err_q[ERR_UNEXP_IDX];
    assign err_to_o    = err_q[ERR_TO_IDX];

endmodule

// File: rtl/wr_handshake_tracker.sv
// Multi-channel AXI write-response tracker: independent per-channel trackers plus a global busy flag.
module wr_handshake_tracker
    import axi_hs_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CNT_W          = cnt_w(MAX_OUTSTANDING),
    localparam int TO_W           = to_w(TIMEOUT_CYCLES)
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [NUM_CH-1:0]       Channel_Request,
    output logic [NUM_CH-1:0]       Req_Ready,
    input  logic [NUM_CH-1:0]       Valid_Signal,
    input  logic [NUM_CH-1:0]       Ready_Signal,
    output logic [NUM_CH-1:0]       HandShake_Done,
    output logic [NUM_CH*CNT_W-1:0] Outstanding,
    output logic                    Any_Busy,
    output logic [NUM_CH-1:0]       Err_Unexpected,
    output logic [NUM_CH-1:0]       Err_Timeout,
    input  logic                    Err_Clear
);

    logic [NUM_CH-1:0] busy;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            wr_hs_channel #(
                .MAX_OUTSTANDING(MAX_OUTSTANDING),
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
                .CNT_W          (CNT_W),
                .TO_W           (TO_W)
            ) u_ch (
                .clk        (ACLK),
                .srst       (ARESET),
                .req_i      (Channel_Request[gi]),
                .valid_i    (Valid_Signal[gi]),
                .ready_i    (Ready_Signal[gi]),
                .err_clear_i(Err_Clear),
                .req_ready_o(Req_Ready[gi]),
                .done_o     (HandShake_Done[gi]),
                .cnt_o      (Outstanding[gi*CNT_W +: CNT_W]),
                .busy_o     (busy[gi]),
                .err_unexp_o(Err_Unexpected[gi]),
                .err_to_o   (Err_Timeout[gi])
            );
        end
    endgenerate

    assign Any_Busy = |busy;

endmodule

// File: tb/tb_wr_handshake_tracker.sv
// Directed-vector bench for wr_handshake_tracker (NUM_CH=4, MAX=8, TIMEOUT=16).
module tb_wr_handshake_tracker;

    localparam int NUM_CH = 4;
    localparam int MAXO   = 8;
    localparam int TO     = 16;
    localparam int CW     = 4;

    logic                   ACLK = 1'b0;
    logic                   ARESET;
    logic [NUM_CH-1:0]      Channel_Request, Req_Ready, Valid_Signal, Ready_Signal;
    logic [NUM_CH-1:0]      HandShake_Done, Err_Unexpected, Err_Timeout;
    logic [NUM_CH*CW-1:0]   Outstanding;
    logic                   Any_Busy, Err_Clear;

    int n_checks = 0;
    int n_pass   = 0;

    wr_handshake_tracker #(
        .NUM_CH(NUM_CH), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .Channel_Request(Channel_Request), .Req_Ready(Req_Ready),
        .Valid_Signal(Valid_Signal), .Ready_Signal(Ready_Signal),
        .HandShake_Done(HandShake_Done), .Outstanding(Outstanding),
        .Any_Busy(Any_Busy), .Err_Unexpected(Err_Unexpected),
        .Err_Timeout(Err_Timeout), .Err_Clear(Err_Clear)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-14s got=%0h", tag, got);
        end else begin
            $display("FAIL %-14s got=%0h required=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] outs(input int ch);
        return Outstanding[ch*CW +: CW];
    endfunction

    task automatic do_reset();
        ARESET = 1'b1;
        tick(2);
        ARESET = 1'b0;
    endtask

    initial begin
        ARESET = 1'b0; Channel_Request = '0; Valid_Signal = '0;
        Ready_Signal = '0; Err_Clear = 1'b0;
        #2;
        do_reset();
        check("rst_ready", Req_Ready, 4'hF);
        check("rst_outs", Outstanding, 0);
        check("rst_busy", Any_Busy, 0);
        check("rst_done", HandShake_Done, 0);
        check("rst_errs", {Err_Unexpected, Err_Timeout}, 0);

        // 1: single request and response on ch0
        Channel_Request[0] = 1'b1; tick(); Channel_Request[0] = 1'b0;
        check("t1_cnt1", outs(0), 1);
        check("t1_busy", Any_Busy, 1);
        tick(3);
        check("t1_nodone", HandShake_Done, 0);
        Valid_Signal[0] = 1'b1; Ready_Signal[0] = 1'b1; tick();
        Valid_Signal[0] = 1'b0; Ready_Signal[0] = 1'b0;
        check("t1_cnt0", outs(0), 0);
        check("t1_done", HandShake_Done, 4'b0001);
        tick();
        check("t1_done_end", HandShake_Done, 0);
        check("t1_errs", {Err_Unexpected, Err_Timeout}, 0);

        // 2: fill ch1 to MAX, drop ninth, drain one
        Channel_Request[1] = 1'b1; tick(MAXO);
        check("t2_full", outs(1), MAXO);
        check("t2_notready", Req_Ready, 4'b1101);
        tick();
        Channel_Request[1] = 1'b0;
        check("t2_drop", outs(1), MAXO);
        Valid_Signal[1] = 1'b1; Ready_Signal[1] = 1'b1; tick();
        Valid_Signal[1] = 1'b0; Ready_Signal[1] = 1'b0;
        check("t2_cnt7", outs(1), 7);
        check("t2_ready", Req_Ready, 4'hF);

        // 3: simultaneous accept and response on ch2 with cnt=3
        Channel_Request[2] = 1'b1; tick(3);
        check("t3_cnt3", outs(2), 3);
        Valid_Signal[2] = 1'b1; Ready_Signal[2] = 1'b1; tick();
        Channel_Request[2] = 1'b0; Valid_Signal[2] = 1'b0; Ready_Signal[2] = 1'b0;
        check("t3_same", outs(2), 3);
        check("t3_done", HandShake_Done, 4'b0100);

        // 4: unexpected response on idle ch3, then clear
        Valid_Signal[3] = 1'b1; Ready_Signal[3] = 1'b1; tick();
        Valid_Signal[3] = 1'b0; Ready_Signal[3] = 1'b0;
        check("t4_unexp", Err_Unexpected, 4'b1000);
        check("t4_nodone", HandShake_Done, 0);
        check("t4_cnt0", outs(3), 0);
        Err_Clear = 1'b1; tick(); Err_Clear = 1'b0;
        check("t4_clear", Err_Unexpected, 0);
        Err_Clear = 1'b1; Valid_Signal[3] = 1'b1; Ready_Signal[3] = 1'b1; tick();
        Err_Clear = 1'b0; Valid_Signal[3] = 1'b0; Ready_Signal[3] = 1'b0;
        check("t4_setwins", Err_Unexpected, 4'b1000);

        // 5: timeout on ch0 after exactly 16 waiting cycles
        do_reset();
        Channel_Request[0] = 1'b1; tick(); Channel_Request[0] = 1'b0;
        tick(TO - 1);
        check("t5_notyet", Err_Timeout, 0);
        tick();
        check("t5_timeout", Err_Timeout, 4'b0001);
        check("t5_unexp", Err_Unexpected, 0);

        // 6: reset in the middle of traffic
        Channel_Request[1] = 1'b1; tick(5); Channel_Request[1] = 1'b0;
        check("t6_cnt5", outs(1), 5);
        ARESET = 1'b1; tick(); ARESET = 1'b0;
        check("t6_outs", Outstanding, 0);
        check("t6_busy", Any_Busy, 0);
        check("t6_done", HandShake_Done, 0);
        check("t6_errs", {Err_Unexpected, Err_Timeout}, 0);
        check("t6_ready", Req_Ready, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
